// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: add/sub/logic under a 3-bit function code, ripple carry out,
// plus a registered copy of result and carry with synchronous active-high reset.
module alu_bit_slice (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] c,
    output logic       f,
    output logic       cout,
    output logic       f_q,
    output logic       cout_q
);

    logic bx;

    assign bx = b ^ c[0];

    // Carry is produced for every code so the chain stays defined during logic ops.
    assign cout = (a & bx) | (a & cin) | (bx & cin);

    always_comb begin
        f = 1'b0;
        unique case (c)
            3'b000:  f = a ^ b ^ cin;
            3'b001:  f = a ^ ~b ^ cin;
            3'b010:  f = a | b;
            3'b011:  f = a | ~b;
            3'b100:  f = a & b;
            3'b101:  f = a & ~b;
            3'b110:  f = ~a;
            3'b111:  f = ~b;
            default: f = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q    <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            f_q    <= f;
            cout_q <= cout;
        end
    end

endmodule

// File: tb/tb_alu_bit_slice.sv
// Self-checking bench for alu_bit_slice: expected values are queued when stimulus
// is driven and popped when the DUT output is sampled.
module tb_alu_bit_slice;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       cin;
    logic [2:0] c;
    logic       f;
    logic       cout;
    logic       f_q;
    logic       cout_q;

    typedef struct packed {
        logic f;
        logic cout;
    } exp_t;

    exp_t q[$];
    int unsigned vectors;
    int unsigned miscompares;

    alu_bit_slice dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .c      (c),
        .f      (f),
        .cout   (cout),
        .f_q    (f_q),
        .cout_q (cout_q)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model written arithmetically rather than as gate equations.
    function automatic exp_t model(input logic [2:0] fc, input logic ia, input logic ib,
                                   input logic ic);
        exp_t r;
        int sum_b;
        int sum_bx;
        sum_b  = int'(ia) + int'(ib) + int'(ic);
        sum_bx = int'(ia) + int'(ib ^ fc[0]) + int'(ic);
        r.cout = (sum_bx >= 2);
        case (fc)
            3'd0: r.f = (sum_b % 2) == 1;
            3'd1: r.f = (sum_bx % 2) == 1;
            3'd2: r.f = ia || ib;
            3'd3: r.f = ia || !ib;
            3'd4: r.f = ia && ib;
            3'd5: r.f = ia && !ib;
            3'd6: r.f = !ia;
            default: r.f = !ib;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [2:0] fc, input logic ia, input logic ib, input logic ic);
        c   = fc;
        a   = ia;
        b   = ib;
        cin = ic;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        drive(3'b000, 1'b1, 1'b1, 1'b1);
        q.push_back('0);
        @(posedge clk);
        #1;
        e = q.pop_front();
        vectors++;
        if ({f_q, cout_q} !== {e.f, e.cout}) begin
            miscompares++;
            $display("FAIL reset_state: got f_q=%b cout_q=%b want f_q=%b cout_q=%b",
                     f_q, cout_q, e.f, e.cout);
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        exp_t e;
        logic [5:0] v;
        for (int unsigned i = 0; i < 64; i++) begin
            v = 6'(i);
            drive(v[5:3], v[1], v[0], v[2]);
            q.push_back(model(v[5:3], v[1], v[0], v[2]));
            #1;
            e = q.pop_front();
            vectors++;
            if ({f, cout} !== {e.f, e.cout}) begin
                miscompares++;
                $display("FAIL sweep[%0d]: got f=%b cout=%b want f=%b cout=%b",
                         i, f, cout, e.f, e.cout);
            end
            #19;
        end
    endtask

    task automatic test_arith_corners();
        // {c, a, b, cin, f, cout}
        logic [7:0] tbl [4] = '{
            {3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1},
            {3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
            {3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
            {3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}
        };
        exp_t e;
        for (int unsigned i = 0; i < 4; i++) begin
            drive(tbl[i][7:5], tbl[i][4], tbl[i][3], tbl[i][2]);
            q.push_back({tbl[i][1], tbl[i][0]});
            #1;
            e = q.pop_front();
            vectors++;
            if ({f, cout} !== {e.f, e.cout}) begin
                miscompares++;
                $display("FAIL arith_corner[%0d]: got f=%b cout=%b want f=%b cout=%b",
                         i, f, cout, e.f, e.cout);
            end
            #9;
        end
    endtask

    task automatic test_logic_cin();
        exp_t e;
        // AND-NOT with a=1,b=0: bx=1 and a=1 so carry is 1 independent of cin.
        for (int unsigned k = 0; k < 2; k++) begin
            drive(3'b101, 1'b1, 1'b0, k[0]);
            q.push_back('{f: 1'b1, cout: 1'b1});
            #1;
            e = q.pop_front();
            vectors++;
            if ({f, cout} !== {e.f, e.cout}) begin
                miscompares++;
                $display("FAIL andnot_cin%0d: got f=%b cout=%b want f=%b cout=%b",
                         k, f, cout, e.f, e.cout);
            end
            #9;
        end
        for (int unsigned k = 0; k < 4; k++) begin
            drive(3'b111, k[1], 1'b0, k[0]);
            q.push_back('{f: 1'b1, cout: model(3'b111, k[1], 1'b0, k[0]).cout});
            #1;
            e = q.pop_front();
            vectors++;
            if ({f, cout} !== {e.f, e.cout}) begin
                miscompares++;
                $display("FAIL notb[%0d]: got f=%b cout=%b want f=%b cout=%b",
                         k, f, cout, e.f, e.cout);
            end
            #9;
        end
    endtask

    task automatic test_registered();
        exp_t e;
        exp_t held;
        @(negedge clk);
        drive(3'b000, 1'b1, 1'b1, 1'b0);
        q.push_back('{f: 1'b0, cout: 1'b1});
        @(posedge clk);
        #1;
        e = q.pop_front();
        held = e;
        vectors++;
        if ({f_q, cout_q} !== {e.f, e.cout}) begin
            miscompares++;
            $display("FAIL reg_load1: got f_q=%b cout_q=%b want f_q=%b cout_q=%b",
                     f_q, cout_q, e.f, e.cout);
        end
        drive(3'b000, 1'b1, 1'b0, 1'b0);
        q.push_back(held);
        #3;
        e = q.pop_front();
        vectors++;
        if ({f_q, cout_q} !== {e.f, e.cout}) begin
            miscompares++;
            $display("FAIL reg_hold: got f_q=%b cout_q=%b want f_q=%b cout_q=%b",
                     f_q, cout_q, e.f, e.cout);
        end
        q.push_back('{f: 1'b1, cout: 1'b0});
        @(posedge clk);
        #1;
        e = q.pop_front();
        vectors++;
        if ({f_q, cout_q} !== {e.f, e.cout}) begin
            miscompares++;
            $display("FAIL reg_load2: got f_q=%b cout_q=%b want f_q=%b cout_q=%b",
                     f_q, cout_q, e.f, e.cout);
        end
    endtask

    task automatic test_sync_reset();
        exp_t e;
        @(negedge clk);
        drive(3'b000, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        q.push_back('{f: 1'b0, cout: 1'b0});
        q.push_back('{f: 1'b1, cout: 1'b1});
        @(posedge clk);
        #1;
        e = q.pop_front();
        vectors++;
        if ({f_q, cout_q} !== {e.f, e.cout}) begin
            miscompares++;
            $display("FAIL rst_regs: got f_q=%b cout_q=%b want f_q=%b cout_q=%b",
                     f_q, cout_q, e.f, e.cout);
        end
        e = q.pop_front();
        vectors++;
        if ({f, cout} !== {e.f, e.cout}) begin
            miscompares++;
            $display("FAIL rst_comb: got f=%b cout=%b want f=%b cout=%b",
                     f, cout, e.f, e.cout);
        end
        @(negedge clk);
        rst = 1'b0;
        q.push_back('{f: 1'b1, cout: 1'b1});
        @(posedge clk);
        #1;
        e = q.pop_front();
        vectors++;
        if ({f_q, cout_q} !== {e.f, e.cout}) begin
            miscompares++;
            $display("FAIL rst_release: got f_q=%b cout_q=%b want f_q=%b cout_q=%b",
                     f_q, cout_q, e.f, e.cout);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_sweep();
        test_arith_corners();
        test_logic_cin();
        test_registered();
        test_sync_reset();
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d leftover entries want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
